// File: rtl/fetch_unit.sv
// Generic FIFO with synchronous flush, used for both the tag queue and the instruction buffer.
// Latency: a pushed word reaches popDat on the cycle after the push.
// Backpressure: none inside; the caller never pushes when full and never pops when empty.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       pushDat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       popDat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= pushDat;
        wrPtr      <= wrPtr + AW'(1);
      end
      if (pop) rdPtr <= rdPtr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign popDat = mem[rdPtr];
endmodule

// Sequential instruction fetcher feeding the core from a variable-latency memory.
// Latency: memory latency plus one cycle from response to instr_valid; no bypass.
// Backpressure: requests stop once buffered plus outstanding words reach DEPTH.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t        state;
  state_t        stateNxt;
  logic [31:0]   fetchPc;
  logic          running;
  logic [CW-1:0] discard;
  logic [CW-1:0] discardNxt;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] inflightNxt;
  logic          issue;
  logic          push;
  logic          pop;
  logic [31:0]   tagPc;
  logic [63:0]   headDat;

  assign issue       = mem_req & mem_gnt;
  assign pop         = instr_valid & instr_ready;
  assign push        = mem_rvalid & (state == RUN) & ~redirect;
  assign inflightNxt = outstanding + CW'(issue) - CW'(mem_rvalid);

  assign mem_req     = running & ((SW'(count) + SW'(outstanding)) < SW'(DEPTH));
  assign mem_addr    = fetchPc;
  assign instr_valid = (count != '0);
  assign instr       = headDat[63:32];
  assign instr_pc    = headDat[31:0];

  // Tag queue is never flushed: it stays aligned with every in-flight response, dropped or not.
  fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) tagQ (
    .clk     (clk),
    .rst     (rst),
    .flush   (1'b0),
    .push    (issue),
    .pushDat (fetchPc),
    .pop     (mem_rvalid),
    .popDat  (tagPc),
    .count   (outstanding)
  );

  fetch_fifo #(.WIDTH(64), .DEPTH(DEPTH)) instrQ (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect),
    .push    (push),
    .pushDat ({mem_rdata, tagPc}),
    .pop     (pop),
    .popDat  (headDat),
    .count   (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetchPc <= RESET_PC;
      running <= 1'b0;
      state   <= RUN;
      discard <= '0;
    end else begin
      running <= 1'b1;
      state   <= stateNxt;
      discard <= discardNxt;
      if (redirect)   fetchPc <= {redirect_pc[31:2], 2'b00};
      else if (issue) fetchPc <= fetchPc + 32'd4;
    end
  end

  // A redirect re-derives the drop count from scratch, so back-to-back redirects never double count.
  always_comb begin
    stateNxt   = state;
    discardNxt = discard;
    if (redirect) begin
      discardNxt = inflightNxt;
      stateNxt   = (inflightNxt != '0) ? DRAIN : RUN;
    end else if (state == DRAIN && mem_rvalid) begin
      discardNxt = discard - CW'(1);
      if (discard == CW'(1)) stateNxt = RUN;
    end
  end

  assert property (@(posedge clk) disable iff (!rst) mem_rvalid |-> (outstanding != '0));
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with random latency and grant, plus a
// stream model where every fetch epoch (reset or redirect) is a sequential run from its start pc.
module tb_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_gnt, mem_rvalid, instr_valid, instr_ready, redirect;
  logic [31:0] mem_addr, mem_rdata, instr, instr_pc, redirect_pc;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; int ep; } pop_t;
  typedef struct { logic [31:0] addr; int ep; } iss_t;

  pend_t       pend[$];
  pop_t        popLog[$];
  iss_t        issLog[$];
  logic [31:0] epStart[$];
  int          cyc, ep, lastDue, badValid, maxPend;
  int          gntPct, readyPct, latMin, latMax;
  logic [31:0] wordKey;
  int          checks, passes;

  // Every delivered word must continue its epoch's sequential run and carry that address's data.
  function automatic int streamErrors();
    int errs = 0;
    int curEp = -1;
    int n = 0;
    logic [31:0] expPc;
    foreach (popLog[i]) begin
      if (popLog[i].ep != curEp) begin
        curEp = popLog[i].ep;
        n = 0;
      end
      expPc = epStart[curEp] + 32'(4 * n);
      if (popLog[i].pc !== expPc || popLog[i].ins !== (expPc ^ wordKey)) errs++;
      n++;
    end
    return errs;
  endfunction

  function automatic int issueErrors();
    int errs = 0;
    int curEp = -1;
    int n = 0;
    foreach (issLog[i]) begin
      if (issLog[i].ep != curEp) begin
        curEp = issLog[i].ep;
        n = 0;
      end
      if (issLog[i].addr !== epStart[curEp] + 32'(4 * n)) errs++;
      n++;
    end
    return errs;
  endfunction

  task automatic clearModel();
    pend.delete();
    popLog.delete();
    issLog.delete();
    epStart.delete();
    epStart.push_back(RESET_PC);
    ep = 0; lastDue = cyc; badValid = 0; maxPend = 0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
  endtask

  task automatic drive();
    mem_gnt     = (int'($urandom_range(99)) < gntPct);
    instr_ready = (int'($urandom_range(99)) < readyPct);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = pend[0].addr ^ wordKey;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end
  endtask

  task automatic commit();
    logic iss, pp, rsp, redir;
    logic [31:0] tgt;
    int due;
    pop_t p;
    iss_t s;
    pend_t q;
    iss   = mem_req & mem_gnt;
    pp    = instr_valid & instr_ready;
    rsp   = mem_rvalid;
    redir = redirect;
    tgt   = {redirect_pc[31:2], 2'b00};
    if (pp) begin
      p.pc = instr_pc; p.ins = instr; p.ep = ep;
      popLog.push_back(p);
    end
    if (iss) begin
      s.addr = mem_addr; s.ep = ep;
      issLog.push_back(s);
      due = cyc + int'($urandom_range(latMax, latMin));
      if (due <= lastDue) due = lastDue + 1;
      lastDue = due;
      q.addr = mem_addr; q.due = due;
      pend.push_back(q);
    end
    if (rsp) void'(pend.pop_front());
    if (pend.size() > maxPend) maxPend = pend.size();
    if (redir) begin
      epStart.push_back(tgt);
      ep++;
    end
    @(posedge clk); #1; cyc++;
    if (redir && instr_valid) badValid++;
    redirect = 1'b0;
  endtask

  task automatic tick();
    drive();
    commit();
  endtask

  task automatic doReset();
    rst = 1'b0;
    clearModel();
    @(posedge clk); #1; cyc++;
    rst = 1'b1;
  endtask

  // Two words buffered (0, 4) and two slow requests (8, 12) still outstanding.
  task automatic fillTwoTwo();
    doReset();
    gntPct = 100; readyPct = 0; latMin = 1; latMax = 1;
    repeat (3) tick();
    latMin = 20; latMax = 20;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    clearModel();
    #1 rst = 1'b0;
    #2;
    checks++;
    if ({mem_req, instr_valid} !== 2'b00 || mem_addr !== RESET_PC || instr !== 32'h0 || instr_pc !== 32'h0)
      $display("FAIL reset_outputs: req=%0b valid=%0b addr=%h instr=%h pc=%h, want 0 0 %h 0 0",
               mem_req, instr_valid, mem_addr, instr, instr_pc, RESET_PC);
    else passes++;
    @(posedge clk); #1; cyc++;
    rst = 1'b1;
    checks++;
    if (mem_req !== 1'b0) $display("FAIL reset_req_before_edge: req=%0b want 0", mem_req);
    else passes++;
    gntPct = 0; readyPct = 0; latMin = 1; latMax = 1;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== RESET_PC)
      $display("FAIL reset_first_req: req=%0b addr=%h want 1 %h", mem_req, mem_addr, RESET_PC);
    else passes++;
  endtask

  task automatic test_stream();
    int gaps = 0;
    bit seen = 0;
    doReset();
    gntPct = 100; readyPct = 100; latMin = 2; latMax = 2; wordKey = 32'h0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (seen && !instr_valid) gaps++;
      if (instr_valid) seen = 1;
    end
    checks++;
    if (gaps !== 0 || popLog.size() < 50)
      $display("FAIL stream_rate: gaps=%0d pops=%0d want 0 gaps and >=50 pops", gaps, popLog.size());
    else passes++;
    checks++;
    if (popLog.size() == 0 || popLog[0].pc !== RESET_PC || popLog[0].ins !== RESET_PC)
      $display("FAIL stream_first: pops=%0d want first pc/instr %h", popLog.size(), RESET_PC);
    else passes++;
    checks++;
    if (streamErrors() !== 0 || issueErrors() !== 0)
      $display("FAIL stream_order: stream errs=%0d issue errs=%0d want 0", streamErrors(), issueErrors());
    else passes++;
  endtask

  task automatic test_backpressure();
    doReset();
    gntPct = 100; readyPct = 0; latMin = 1; latMax = 1; wordKey = $urandom;
    repeat (12) tick();
    checks++;
    if (issLog.size() !== 4 || issueErrors() !== 0 || mem_req !== 1'b0)
      $display("FAIL bp_grants: grants=%0d errs=%0d req=%0b want 4 0 0", issLog.size(), issueErrors(), mem_req);
    else passes++;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0)
      $display("FAIL bp_head: valid=%0b pc=%h want 1 0", instr_valid, instr_pc);
    else passes++;
    readyPct = 100;
    tick();
    checks++;
    if (mem_req !== 1'b1) $display("FAIL bp_req_after_pop: req=%0b want 1", mem_req);
    else passes++;
    repeat (3) tick();
    checks++;
    if (popLog.size() !== 4) $display("FAIL bp_pop_count: pops=%0d want 4", popLog.size());
    else passes++;
    for (int i = 0; i < 4 && i < popLog.size(); i++) begin
      checks++;
      if (popLog[i].pc !== 32'(4 * i) || popLog[i].ins !== (32'(4 * i) ^ wordKey))
        $display("FAIL bp_pop_%0d: pc=%h instr=%h want %h %h", i, popLog[i].pc, popLog[i].ins,
                 32'(4 * i), 32'(4 * i) ^ wordKey);
      else passes++;
    end
  endtask

  task automatic test_redirect();
    wordKey = $urandom;
    fillTwoTwo();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || mem_req !== 1'b0 || pend.size() !== 2)
      $display("FAIL redir_setup: valid=%0b pc=%h req=%0b outstanding=%0d want 1 0 0 2",
               instr_valid, instr_pc, mem_req, pend.size());
    else passes++;
    drive();
    redirect = 1'b1; redirect_pc = 32'h103;
    commit();
    checks++;
    if (instr_valid !== 1'b0 || mem_addr !== 32'h100)
      $display("FAIL redir_flush: valid=%0b addr=%h want 0 00000100", instr_valid, mem_addr);
    else passes++;
    latMin = 1; latMax = 1; readyPct = 100;
    repeat (40) tick();
    checks++;
    if (popLog.size() < 2 || popLog[0].pc !== 32'h100 || popLog[1].pc !== 32'h104)
      $display("FAIL redir_first: pops=%0d pc0=%h pc1=%h want 100 104", popLog.size(),
               popLog.size() > 0 ? popLog[0].pc : 32'hx, popLog.size() > 1 ? popLog[1].pc : 32'hx);
    else passes++;
    checks++;
    if (streamErrors() !== 0) $display("FAIL redir_stream: errs=%0d want 0", streamErrors());
    else passes++;
  endtask

  task automatic test_redirect_collide();
    bit found = 0;
    int nPop, hits;
    logic [31:0] oldHead, tgt;
    bit gotFirst = 0;
    logic [31:0] firstPc = '0;
    doReset();
    gntPct = 100; readyPct = 100; latMin = 2; latMax = 2; wordKey = $urandom;
    repeat (10) tick();
    for (int i = 0; i < 50; i++) begin
      drive();
      if (mem_req && mem_gnt && mem_rvalid && instr_valid && instr_ready) begin
        found = 1;
        break;
      end
      commit();
    end
    checks++;
    if (!found) $display("FAIL collide_setup: no cycle with grant, response and pop together");
    else passes++;
    oldHead = instr_pc; nPop = popLog.size();
    redirect = 1'b1; redirect_pc = $urandom;
    tgt = {redirect_pc[31:2], 2'b00};
    commit();
    checks++;
    if (instr_valid !== 1'b0 || popLog.size() !== nPop + 1 || mem_addr !== tgt)
      $display("FAIL collide_flush: valid=%0b pops=%0d addr=%h want 0 %0d %h",
               instr_valid, popLog.size(), mem_addr, nPop + 1, tgt);
    else passes++;
    repeat (30) tick();
    hits = 0;
    foreach (popLog[i]) begin
      if (popLog[i].pc === oldHead) hits++;
      if (popLog[i].ep == 1 && !gotFirst) begin
        gotFirst = 1;
        firstPc = popLog[i].pc;
      end
    end
    checks++;
    if (hits !== 1 || !gotFirst || firstPc !== tgt)
      $display("FAIL collide_stream: old head seen %0d times, first new pc=%h want 1 and %h", hits, firstPc, tgt);
    else passes++;
    checks++;
    if (streamErrors() !== 0 || maxPend > DEPTH)
      $display("FAIL collide_order: errs=%0d max outstanding=%0d want 0 and <=%0d", streamErrors(), maxPend, DEPTH);
    else passes++;
  endtask

  task automatic test_held_request();
    logic [31:0] expAddr;
    bit gotFirst = 0;
    logic [31:0] firstIss = '0;
    doReset();
    gntPct = 100; readyPct = 100; latMin = 1; latMax = 1; wordKey = $urandom;
    for (int i = 0; i < 40 && mem_addr !== 32'h20; i++) tick();
    checks++;
    if (mem_addr !== 32'h20) $display("FAIL held_reach: addr=%h want 00000020", mem_addr);
    else passes++;
    gntPct = 0;
    for (int i = 0; i < 5; i++) begin
      drive();
      if (i == 2) begin
        redirect = 1'b1; redirect_pc = 32'h200;
      end
      expAddr = (i <= 2) ? 32'h20 : 32'h200;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== expAddr)
        $display("FAIL held_cycle_%0d: req=%0b addr=%h want 1 %h", i, mem_req, mem_addr, expAddr);
      else passes++;
      commit();
    end
    gntPct = 100;
    repeat (20) tick();
    foreach (issLog[i]) if (issLog[i].ep == 1 && !gotFirst) begin
      gotFirst = 1;
      firstIss = issLog[i].addr;
    end
    checks++;
    if (!gotFirst || firstIss !== 32'h200 || streamErrors() !== 0 || issueErrors() !== 0)
      $display("FAIL held_after: first issue=%h stream errs=%0d issue errs=%0d want 200 0 0",
               firstIss, streamErrors(), issueErrors());
    else passes++;
  endtask

  task automatic test_midreset();
    wordKey = $urandom;
    fillTwoTwo();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({mem_req, instr_valid} !== 2'b00 || mem_addr !== RESET_PC || instr !== 32'h0 || instr_pc !== 32'h0)
      $display("FAIL midreset_outputs: req=%0b valid=%0b addr=%h instr=%h pc=%h want all reset values",
               mem_req, instr_valid, mem_addr, instr, instr_pc);
    else passes++;
    clearModel();
    @(posedge clk); #1; cyc++;
    rst = 1'b1;
    checks++;
    if (mem_req !== 1'b0) $display("FAIL midreset_req_low: req=%0b want 0", mem_req);
    else passes++;
    gntPct = 100; readyPct = 100; latMin = 1; latMax = 3;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== RESET_PC)
      $display("FAIL midreset_restart: req=%0b addr=%h want 1 %h", mem_req, mem_addr, RESET_PC);
    else passes++;
    repeat (30) tick();
    checks++;
    if (popLog.size() == 0 || popLog[0].pc !== RESET_PC || streamErrors() !== 0)
      $display("FAIL midreset_stream: pops=%0d errs=%0d want first pc %h and 0 errs",
               popLog.size(), streamErrors(), RESET_PC);
    else passes++;
  endtask

  task automatic test_random();
    doReset();
    wordKey = $urandom;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        gntPct   = int'($urandom_range(100, 20));
        readyPct = int'($urandom_range(100, 10));
        latMin   = int'($urandom_range(3, 1));
        latMax   = latMin + int'($urandom_range(4, 0));
      end
      drive();
      if ($urandom_range(99) < 4) begin
        redirect = 1'b1; redirect_pc = $urandom;
      end
      commit();
    end
    checks++;
    if (streamErrors() !== 0 || issueErrors() !== 0)
      $display("FAIL random_order: stream errs=%0d issue errs=%0d want 0", streamErrors(), issueErrors());
    else passes++;
    checks++;
    if (badValid !== 0 || maxPend > DEPTH)
      $display("FAIL random_flush_credit: valid after redirect=%0d max outstanding=%0d want 0 and <=%0d",
               badValid, maxPend, DEPTH);
    else passes++;
    checks++;
    if (popLog.size() < 200) $display("FAIL random_progress: pops=%0d want >=200", popLog.size());
    else passes++;
  endtask

  initial begin
    checks = 0; passes = 0; cyc = 0; wordKey = '0;
    gntPct = 0; readyPct = 0; latMin = 1; latMax = 1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_collide();
    test_held_request();
    test_midreset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1);
  end
endmodule
